// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX core between N byte requesters.
// Define TX_ARB_TIMEOUT_EN to build the watchdog for a core that never reports done.
module uart_tx_arbiter #(
   parameter int          N       = 4,
   parameter int          IDW     = 2,
   parameter logic [23:0] TIMEOUT = 24'd200000
) (
   input  logic           clk,
   input  logic           arst,
   input  logic [N-1:0]   req,
   input  logic [8*N-1:0] req_data,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   ack,
   output logic [IDW-1:0] active_id,
   output logic           tx_en,
   output logic [7:0]     tx_data,
   input  logic           tx_busy,
   input  logic           tx_done,
   output logic           timeout_err
);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

   state_t         state, state_d;
   logic [IDW-1:0] ptr, ptr_d, win, id_d, next_ptr;
   logic [N-1:0]   gnt_d, ack_d, rot;
   logic [2*N-1:0] req2;
   logic [7:0]     win_data, data_d;
   logic           found, tx_en_d, timeout_hit;

   if (N < 2 || N > 8 || IDW < $clog2(N) || TIMEOUT == 24'd0) begin : g_bad_cfg
      $error("uart_tx_arbiter: unsupported N/IDW/TIMEOUT combination");
   end

   // Rotate requests so bit 0 is the requester at ptr; lowest set bit wins.
   assign req2 = {req, req};
   assign rot  = N'(req2 >> ptr);

   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr) + k) % N);
         end
      end
   end

   always_comb begin
      win_data = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (win == IDW'(i)) win_data = req_data[8*i +: 8];
      end
   end

   assign next_ptr = (active_id == IDW'(N - 1)) ? '0 : active_id + IDW'(1);

`ifdef TX_ARB_TIMEOUT_EN
   logic [23:0] cnt;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         cnt         <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeout_hit;
         if (state == LOAD) cnt <= '0;
         else if (state == WAIT_BUSY || state == WAIT_DONE) cnt <= cnt + 24'd1;
      end
   end

   // A done arriving in the expiry cycle still completes the frame normally.
   assign timeout_hit = (cnt == TIMEOUT) &&
                        (state == WAIT_BUSY || (state == WAIT_DONE && !tx_done));
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d = state;
      gnt_d   = '0;
      ack_d   = '0;
      tx_en_d = 1'b0;
      id_d    = active_id;
      data_d  = tx_data;
      ptr_d   = ptr;
      case (state)
         IDLE: begin
            if (found) begin
               id_d    = win;
               data_d  = win_data;
               gnt_d   = N'(1) << win;
               tx_en_d = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD:      state_d = WAIT_BUSY;
         // Done is ignored here so a stale pulse from the previous frame is not taken.
         WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (tx_done) begin
               ack_d   = N'(1) << active_id;
               ptr_d   = next_ptr;
               state_d = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase
      if (timeout_hit) begin
         ack_d   = '0;
         ptr_d   = next_ptr;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         ack       <= '0;
         tx_en     <= 1'b0;
         tx_data   <= 8'h00;
         active_id <= '0;
      end else begin
         state     <= state_d;
         ptr       <= ptr_d;
         gnt       <= gnt_d;
         ack       <= ack_d;
         tx_en     <= tx_en_d;
         tx_data   <= data_d;
         active_id <= id_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester agents, a TX core model and
// a grant/ack scoreboard. Watchdog scenario is built only with TX_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int IDW = 2;
   localparam int FRAME = 12;

   logic           clk = 1'b0;
   logic           arst = 1'b1;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   gnt, ack;
   logic [IDW-1:0] active_id;
   logic           tx_en, tx_busy, tx_done, timeout_err;
   logic [7:0]     tx_data;

   typedef struct packed {logic [IDW-1:0] id; logic [7:0] data;} exp_t;
   typedef struct packed {
      logic [N-1:0] g; logic [N-1:0] a; logic en; logic busy; logic done;
      logic to; logic [IDW-1:0] id; logic [7:0] d;
   } snap_t;

   exp_t           exp_q[$];
   logic [IDW-1:0] ack_q[$];
   int             n_cmp = 0, n_bad = 0;
   int             add_req[N];
   int             taken[N];
   bit             outst[N];
   bit             stale_done = 1'b0, hang = 1'b0;
   int             ccnt;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(24'd1000)) dut (
      .clk(clk), .arst(arst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
      .active_id(active_id), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
      .tx_done(tx_done), .timeout_err(timeout_err)
   );

   // Requesters: raise req when a new request is queued and none is in flight,
   // drop it after gnt.
   initial begin
      req = '0;
      for (int i = 0; i < N; i++) begin add_req[i] = 0; taken[i] = 0; outst[i] = 1'b0; end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (!arst) begin
               req[i] = 1'b0; outst[i] = 1'b0; taken[i] = add_req[i];
            end else begin
               if (gnt[i]) begin req[i] = 1'b0; outst[i] = 1'b1; end
               if (ack[i] || timeout_err) outst[i] = 1'b0;
               if (!req[i] && !outst[i] && add_req[i] > taken[i]) begin
                  req[i] = 1'b1; taken[i]++;
               end
            end
         end
      end
   end

   // TX core model: busy two cycles after tx_en, done pulse at end of frame.
   initial begin
      tx_busy = 1'b0; tx_done = 1'b0; ccnt = 0;
      forever begin
         @(negedge clk);
         if (!arst) begin
            ccnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
         end else if (ccnt == 0) begin
            tx_done = 1'b0;
            if (!hang) tx_busy = 1'b0;
            if (tx_en) ccnt = 1;
         end else begin
            ccnt++;
            tx_done = 1'b0;
            if (ccnt == 3) begin tx_busy = 1'b1; tx_done = stale_done; end
            if (ccnt == FRAME) begin
               ccnt = 0;
               if (!hang) begin tx_busy = 1'b0; tx_done = 1'b1; end
            end
         end
      end
   end

   initial begin
      #600_000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "bench did not terminate");
   end

   // Waits for the next cycle with any DUT event; cyc = posedges waited.
   task automatic wait_evt(input int budget, output bit got, output int cyc, output snap_t s);
      got = 1'b0; cyc = 0; s = '0;
      for (int c = 1; c <= budget && !got; c++) begin
         @(posedge clk); #1;
         if (gnt != 0 || ack != 0 || tx_en || timeout_err) begin
            got = 1'b1; cyc = c;
            s.g = gnt; s.a = ack; s.en = tx_en; s.busy = tx_busy; s.done = tx_done;
            s.to = timeout_err; s.id = active_id; s.d = tx_data;
         end
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2 arst = 1'b0;
      #20 arst = 1'b1;
   endtask

   task automatic test_reset();
      bit seen = 1'b0;
      #1 arst = 1'b0;
      #10;
      n_cmp++;
      if ({gnt, ack, tx_en, timeout_err} !== '0) begin
         n_bad++;
         $display("FAIL reset_pulses: gnt=%b ack=%b tx_en=%b timeout_err=%b, required all 0", gnt, ack, tx_en, timeout_err);
      end
      n_cmp++;
      if ({tx_data, active_id} !== '0) begin
         n_bad++;
         $display("FAIL reset_regs: tx_data=%h active_id=%0d, required 00 and 0", tx_data, active_id);
      end
      #10 arst = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (gnt != 0 || ack != 0 || tx_en || timeout_err) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL reset_idle: output activity seen=%0d with req=0, required 0", seen);
      end
   endtask

   task automatic test_single();
      bit got, stuck = 1'b0; int cyc; snap_t s; exp_t e; logic [N-1:0] oh;
      stale_done = 1'b1;
      req_data[15:8] = 8'hA5;
      exp_q.push_back('{id: 2'd1, data: 8'hA5});
      add_req[1]++;
      while ((exp_q.size() > 0 || ack_q.size() > 0) && !stuck) begin
         wait_evt(200, got, cyc, s);
         n_cmp++;
         if (!got) begin
            n_bad++; stuck = 1'b1;
            $display("FAIL single_wait: no event in 200 cycles, still expected %0d grants %0d acks", exp_q.size(), ack_q.size());
         end else if (s.g != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
            if ({s.g, s.en, s.id, s.d} !== {oh, 1'b1, e.id, e.data}) begin
               n_bad++;
               $display("FAIL single_grant: gnt=%b tx_en=%b id=%0d data=%h, required gnt=%b tx_en=1 id=%0d data=%h", s.g, s.en, s.id, s.d, oh, e.id, e.data);
            end
            ack_q.push_back(e.id);
         end else if (s.a != 0 && ack_q.size() > 0) begin
            oh = '0; oh[ack_q.pop_front()] = 1'b1;
            if ({s.a, s.done, s.busy} !== {oh, 1'b1, 1'b0}) begin
               n_bad++;
               $display("FAIL single_ack: ack=%b done=%b busy=%b, required ack=%b one cycle after done", s.a, s.done, s.busy, oh);
            end
         end else begin
            n_bad++;
            $display("FAIL single_stray: gnt=%b ack=%b tx_en=%b to=%b, required no event", s.g, s.a, s.en, s.to);
         end
      end
      stale_done = 1'b0;
      repeat (5) @(posedge clk);
      #1 n_cmp++;
      if ({tx_data, active_id} !== {8'hA5, 2'd1}) begin
         n_bad++;
         $display("FAIL single_hold: tx_data=%h active_id=%0d, required A5 and 1", tx_data, active_id);
      end
   endtask

   task automatic test_contention();
      bit got, stuck = 1'b0, seen = 1'b0; int cyc, ngr = 0; snap_t s; exp_t e; logic [N-1:0] oh;
      pulse_reset();
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      for (int i = 0; i < N; i++) begin
         exp_q.push_back('{id: IDW'(i), data: req_data[8*i +: 8]});
         add_req[i]++;
      end
      while ((exp_q.size() > 0 || ack_q.size() > 0) && !stuck) begin
         wait_evt(200, got, cyc, s);
         n_cmp++;
         if (!got) begin
            n_bad++; stuck = 1'b1;
            $display("FAIL contention_wait: no event in 200 cycles, still expected %0d grants %0d acks", exp_q.size(), ack_q.size());
         end else if (s.g != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
            if ({s.g, s.en, s.id, s.d} !== {oh, 1'b1, e.id, e.data}) begin
               n_bad++;
               $display("FAIL contention_grant: gnt=%b tx_en=%b id=%0d data=%h, required gnt=%b tx_en=1 id=%0d data=%h", s.g, s.en, s.id, s.d, oh, e.id, e.data);
            end
            if (ngr > 0) begin
               n_cmp++;
               if (cyc != 1) begin
                  n_bad++;
                  $display("FAIL contention_overhead: next tx_en %0d cycles after ack, required 1", cyc);
               end
            end
            ngr++;
            ack_q.push_back(e.id);
         end else if (s.a != 0 && ack_q.size() > 0) begin
            oh = '0; oh[ack_q.pop_front()] = 1'b1;
            if ({s.a, s.done, s.busy} !== {oh, 1'b1, 1'b0}) begin
               n_bad++;
               $display("FAIL contention_ack: ack=%b done=%b busy=%b, required ack=%b one cycle after done", s.a, s.done, s.busy, oh);
            end
         end else begin
            n_bad++;
            $display("FAIL contention_stray: gnt=%b ack=%b tx_en=%b to=%b, required no event", s.g, s.a, s.en, s.to);
         end
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (gnt != 0 || ack != 0 || tx_en) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL contention_extra: activity after 4 frames seen=%0d, required 0", seen);
      end
   endtask

   task automatic test_fairness();
      bit got, stuck = 1'b0; int cyc; snap_t s; exp_t e; logic [N-1:0] oh;
      req_data[7:0] = 8'h5A; req_data[23:16] = 8'h7E;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) exp_q.push_back('{id: 2'd0, data: 8'h5A});
         else            exp_q.push_back('{id: 2'd2, data: 8'h7E});
      end
      add_req[0] += 2; add_req[2] += 2;
      while ((exp_q.size() > 0 || ack_q.size() > 0) && !stuck) begin
         wait_evt(200, got, cyc, s);
         n_cmp++;
         if (!got) begin
            n_bad++; stuck = 1'b1;
            $display("FAIL fairness_wait: no event in 200 cycles, still expected %0d grants %0d acks", exp_q.size(), ack_q.size());
         end else if (s.g != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); oh = '0; oh[e.id] = 1'b1;
            if ({s.g, s.en, s.id, s.d} !== {oh, 1'b1, e.id, e.data}) begin
               n_bad++;
               $display("FAIL fairness_grant: gnt=%b tx_en=%b id=%0d data=%h, required gnt=%b tx_en=1 id=%0d data=%h", s.g, s.en, s.id, s.d, oh, e.id, e.data);
            end
            ack_q.push_back(e.id);
         end else if (s.a != 0 && ack_q.size() > 0) begin
            oh = '0; oh[ack_q.pop_front()] = 1'b1;
            if ({s.a, s.done, s.busy} !== {oh, 1'b1, 1'b0}) begin
               n_bad++;
               $display("FAIL fairness_ack: ack=%b done=%b busy=%b, required ack=%b", s.a, s.done, s.busy, oh);
            end
         end else begin
            n_bad++;
            $display("FAIL fairness_stray: gnt=%b ack=%b tx_en=%b to=%b, required no event", s.g, s.a, s.en, s.to);
         end
      end
   endtask

   task automatic test_async_reset();
      bit got, seen = 1'b0; int cyc; snap_t s;
      logic [N-1:0] eg[4] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000};
      logic [N-1:0] ea[4] = '{4'b0000, 4'b0010, 4'b0000, 4'b1000};
      logic [7:0]   ed[4] = '{8'h3C, 8'h00, 8'h96, 8'h00};
      req_data[23:16] = 8'hC3;
      add_req[2]++;
      wait_evt(200, got, cyc, s);
      n_cmp++;
      if (!got || s.g !== 4'b0100 || s.d !== 8'hC3 || !s.en) begin
         n_bad++;
         $display("FAIL areset_grant: got=%0d gnt=%b data=%h tx_en=%b, required gnt=0100 data=C3 tx_en=1", got, s.g, s.d, s.en);
      end
      repeat (6) @(posedge clk);
      #3 arst = 1'b0;
      #1 n_cmp++;
      if ({gnt, ack, tx_en, tx_data, active_id, timeout_err} !== '0) begin
         n_bad++;
         $display("FAIL areset_immediate: gnt=%b ack=%b tx_en=%b data=%h id=%0d, required all 0", gnt, ack, tx_en, tx_data, active_id);
      end
      #20 arst = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (gnt != 0 || ack != 0 || tx_en) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_bad++;
         $display("FAIL areset_no_ack: activity after reset seen=%0d, required 0", seen);
      end
      // Pointer must restart at 0, so requester 1 beats requester 3.
      req_data[15:8] = 8'h3C; req_data[31:24] = 8'h96;
      add_req[1]++; add_req[3]++;
      for (int k = 0; k < 4; k++) begin
         wait_evt(200, got, cyc, s);
         n_cmp++;
         if (!got || s.g !== eg[k] || s.a !== ea[k] || (eg[k] != 0 && s.d !== ed[k])) begin
            n_bad++;
            $display("FAIL areset_after_%0d: got=%0d gnt=%b ack=%b data=%h, required gnt=%b ack=%b data=%h", k, got, s.g, s.a, s.d, eg[k], ea[k], ed[k]);
         end
      end
   endtask

`ifdef TX_ARB_TIMEOUT_EN
   task automatic test_watchdog();
      bit got, seen_ack = 1'b0; int cyc, when = -1; snap_t s;
      hang = 1'b1;
      req_data[7:0] = 8'hE1;
      add_req[0]++;
      wait_evt(200, got, cyc, s);
      n_cmp++;
      if (!got || s.g !== 4'b0001) begin
         n_bad++;
         $display("FAIL watchdog_grant: got=%0d gnt=%b, required 0001", got, s.g);
      end
      for (int c = 0; c < 1100 && when < 0; c++) begin
         @(posedge clk); #1;
         if (ack != 0) seen_ack = 1'b1;
         if (timeout_err) when = c;
      end
      n_cmp++;
      if (when != 1001 || seen_ack) begin
         n_bad++;
         $display("FAIL watchdog_timing: timeout_err at %0d ack_seen=%0d, required 1001 and 0", when, seen_ack);
      end
      @(posedge clk); #1 n_cmp++;
      if (timeout_err !== 1'b0) begin
         n_bad++;
         $display("FAIL watchdog_pulse: timeout_err=%b second cycle, required 0", timeout_err);
      end
      hang = 1'b0;
      repeat (3) @(posedge clk);
      req_data[15:8] = 8'h1E;
      add_req[0]++; add_req[1]++;
      wait_evt(200, got, cyc, s);
      n_cmp++;
      if (!got || s.g !== 4'b0010 || s.d !== 8'h1E) begin
         n_bad++;
         $display("FAIL watchdog_ptr: gnt=%b data=%h, required 0010 and 1E", s.g, s.d);
      end
      repeat (3 * FRAME + 20) @(posedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_async_reset();
`ifdef TX_ARB_TIMEOUT_EN
      test_watchdog();
`endif
      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmit core (`tx_en`/`data`/`busy`/`done` handshake) between N byte requesters. It sits between the requesting blocks (for example, APB register writes and a debug source) and the TX core. It grants one requester at a time, issues a single `tx_en` pulse with the latched byte, tracks the frame through `busy`/`done`, and returns a per-requester completion pulse. An optional watchdog recovers from a core that never signals `done`.

## Interface
- `N`, default 4: number of requesters (2..8).
- `IDW`, default 2: width of the requester index; must be ≥ clog2(N).
- `TIMEOUT`, default 24'd200000: watchdog limit in clk cycles (used only with `TX_ARB_TIMEOUT_EN`).
- `clk`  in  1  system clock; all logic on the rising edge.
- `arst`  in  1  asynchronous reset, active-low.
- `req`  in  N  per-requester level request; the requester holds it high until its `gnt` bit is seen.
- `req_data`  in  8*N  byte for requester i on bits [8i+7:8i]; held stable while `req[i]` is high.
- `gnt`  out  N  one-hot, 1-cycle pulse: the byte has been accepted.
- `ack`  out  N  one-hot, 1-cycle pulse: the frame has been sent (core `done` seen).
- `active_id`  out  IDW  index of the current or last granted requester.
- `tx_en`  out  1  1-cycle start pulse to the TX core.
- `tx_data`  out  8  byte to the TX core; held stable from `tx_en` until return to IDLE.
- `tx_busy`  in  1  core busy.
- `tx_done`  in  1  core frame done; high for at least 1 cycle.
- `timeout_err`  out  1  1-cycle watchdog pulse; constant 0 when the feature is compiled out.

## Operation
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- **IDLE**
  - If `req` is nonzero, select a winner by round robin.
  - The search starts at `ptr` and runs ptr..N-1, then 0..ptr-1.
  - Latch the winner's index into `active_id` and its byte into `tx_data`.
  - Go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `tx_en`=1 and `gnt[active_id]`=1.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**
  - Stay until `tx_busy`=1, then go to WAIT_DONE.
  - `tx_done` is ignored in this state. This guards against a stale `done` left over from the previous frame.
- **WAIT_DONE**
  - Stay until `tx_done`=1.
  - On the next cycle: `ack[active_id]`=1, `ptr`←(active_id+1) mod N, state IDLE.
- **Pointer**
  - `ptr` advances only on completion or timeout, never on grant.
  - The requester just served therefore has the lowest priority in the next arbitration.
- **Requester obligations**
  - Drop `req` in the cycle after `gnt`.
  - A `req` still high in the cycle after `ack` is treated as a new request.
- **Register behaviour**
  - `tx_data` and `active_id` keep their values until the next grant.
  - `gnt`, `ack`, `tx_en` and `timeout_err` are registered and never high for more than 1 cycle.
- **Reset values**
  - `gnt`=0, `ack`=0, `tx_en`=0, `tx_data`=8'h00, `active_id`=0, `timeout_err`=0, `ptr`=0, state IDLE.
- **arst asserted mid-frame**
  - Everything returns to reset values immediately (asynchronously).
  - No `ack` is issued for the interrupted frame.
  - Resetting the TX core is the system's responsibility.

## Timing
- Let cycle T be the first IDLE cycle with `req[i]`=1.
- T+1: LOAD, with `tx_en`=1 and `gnt[i]`=1.
- T+2: WAIT_BUSY.
- If the core raises `tx_done` in cycle D (while in WAIT_DONE), then:
  - D+1: `ack[i]`=1, state IDLE.
  - D+2 at the earliest: the next `tx_en`.
- Back-to-back frames: 2 cycles of arbiter overhead, from `done` to the next `tx_en`.
- Simultaneous requests in the same cycle: exactly one grant, chosen by `ptr` order.
- Requests raised during a frame are queued by level; no request is lost as long as `req` is held.
- `tx_done` seen in the same cycle as `tx_busy` rising is not accepted; `done` must be sampled in WAIT_DONE.

## Configuration
- Macro `TX_ARB_TIMEOUT_EN`.
- **Defined**
  - A 24-bit counter clears on entry to WAIT_BUSY and counts each cycle in WAIT_BUSY and WAIT_DONE.
  - When the counter reaches `TIMEOUT` without `tx_done`, the next cycle gives `timeout_err`=1 for 1 cycle.
  - In that case no `ack` is issued, `ptr`←active_id+1, and the state returns to IDLE.
- **Undefined**
  - No counter is built.
  - `timeout_err` is tied to 0.
  - The FSM can wait in WAIT_BUSY/WAIT_DONE indefinitely.

## Test plan
- **Reset:** hold `arst`=0 for 20 ns, then release. Expect all outputs 0 and `tx_en` low for 100 cycles while `req`=0.
- **Single request:** `req`=4'b0010 with byte 8'hA5, driving a core model or Top_module_TX with div=10417. Expect `gnt`=4'b0010 and `tx_en` in the same cycle, `tx_data`=8'hA5, and `ack`=4'b0010 one cycle after `done`.
- **Contention:** `req`=4'b1111 from reset with bytes 11/22/33/44, each requester holding `req` until its `gnt`. Expect grant order 0,1,2,3 and `tx_data` sequence 11,22,33,44, with exactly 4 `ack` pulses.
- **Fairness:** requester 0 re-requests immediately after each `ack` while requester 2 holds `req`. Expect grants to alternate 0,2,0,2, and no back-to-back grant of 0 while 2 is pending.
- **Async reset mid-frame:** assert `arst` 400 µs after `tx_en` for byte 8'hC3. Expect outputs at reset values immediately, no `ack[i]`, and the next request granted normally after release.
- **Watchdog** (`TX_ARB_TIMEOUT_EN`, `TIMEOUT`=1000): the core model raises `busy` but never `done`. Expect `timeout_err` 1 cycle at 1001 cycles after entering WAIT_BUSY, no `ack`, return to IDLE, and `ptr` advanced.
